// File: rtl/bonsai_pkg.sv
// Shared definitions for the bonsai merge-sort datapath.
// Holds the default item width, the run terminator value and the distributor FSM states.
package bonsai_pkg;

    localparam int BONSAI_DATA_W = 32;
    localparam int BONSAI_TERM   = 0;

    typedef enum logic {
        S_DATA = 1'b0,
        S_TERM = 1'b1
    } dist_state_t;

endpackage

// File: rtl/run_distributor.sv
// Cuts the sorted source stream into runs of RUN_LEN items plus a terminator word.
// Runs are dealt alternately to merger lanes 1 and 2; only the active lane is ever written.
module run_distributor
    import bonsai_pkg::*;
#(
    parameter int                DATA_W  = BONSAI_DATA_W,
    parameter int                RUN_LEN = 4,
    parameter logic [DATA_W-1:0] TERM    = DATA_W'(BONSAI_TERM)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_fifo_in,
    input  logic              i_fifo_in_empty,
    output logic              o_fifo_in_read,
    input  logic              i_fifo_1_ready,
    input  logic              i_fifo_2_ready,
    output logic              o_fifo_1_write,
    output logic              o_fifo_2_write,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    output logic [15:0]       o_runs,
    output logic              o_lane
);

    localparam int CNT_W = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

    dist_state_t      state, state_n;
    logic             lane, lane_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             flush_pend, flush_pend_n;
    logic [15:0]      runs_n;
    logic             ready_lane;
    logic             flush_any;
    logic             do_read;
    logic             do_write;

    assign ready_lane = lane ? i_fifo_2_ready : i_fifo_1_ready;
    assign flush_any  = flush_pend | i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_DATA;
            lane       <= 1'b0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            o_runs     <= 16'd0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            cnt        <= cnt_n;
            flush_pend <= flush_pend_n;
            o_runs     <= runs_n;
        end
    end

    always_comb begin
        state_n      = state;
        lane_n       = lane;
        cnt_n        = cnt;
        flush_pend_n = flush_pend;
        runs_n       = o_runs;
        do_read      = 1'b0;
        do_write     = 1'b0;
        o_data       = i_fifo_in;

        case (state)
            S_DATA: begin
                if (!i_fifo_in_empty && ready_lane) begin
                    do_read  = 1'b1;
                    do_write = 1'b1;
                    cnt_n    = cnt + CNT_W'(1);
                    if (cnt_n == RUN_LEN_C || flush_any) begin
                        state_n      = S_TERM;
                        flush_pend_n = flush_any;
                    end
                end else if (flush_any) begin
                    // A flush with nothing in the run is dropped so no empty runs are emitted.
                    if (cnt != '0) begin
                        state_n      = S_TERM;
                        flush_pend_n = 1'b1;
                    end else begin
                        flush_pend_n = 1'b0;
                    end
                end
            end

            S_TERM: begin
                o_data = TERM;
                if (ready_lane) begin
                    do_write     = 1'b1;
                    cnt_n        = '0;
                    lane_n       = ~lane;
                    runs_n       = o_runs + 16'd1;
                    flush_pend_n = 1'b0;
                    state_n      = S_DATA;
                end
            end

            default: begin
                state_n = S_DATA;
            end
        endcase
    end

    // Strobes are gated by reset directly so they drop the instant reset asserts.
    assign o_fifo_in_read = do_read & i_rst_n;
    assign o_fifo_1_write = do_write & ~lane & i_rst_n;
    assign o_fifo_2_write = do_write & lane & i_rst_n;
    assign o_lane         = lane;

endmodule

// File: tb/tb_run_distributor.sv
// Scoreboard bench for run_distributor: a run-level reference model predicts per-lane
// write streams and per-cycle handshake outcomes; a monitor compares them to the DUT.
module tb_run_distributor;

    localparam int          DW    = 32;
    localparam int          RL    = 4;
    localparam logic [31:0] TERMV = 32'd0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_in = '0;
    logic          fifo_in_empty = 1'b1;
    logic          fifo_in_read;
    logic          ready1 = 1'b0;
    logic          ready2 = 1'b0;
    logic          write1;
    logic          write2;
    logic [DW-1:0] data;
    logic          flush = 1'b0;
    logic [15:0]   runs;
    logic          lane;

    run_distributor #(
        .DATA_W (DW),
        .RUN_LEN(RL),
        .TERM   (TERMV)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fifo_in      (fifo_in),
        .i_fifo_in_empty(fifo_in_empty),
        .o_fifo_in_read (fifo_in_read),
        .i_fifo_1_ready (ready1),
        .i_fifo_2_ready (ready2),
        .o_fifo_1_write (write1),
        .o_fifo_2_write (write2),
        .o_data         (data),
        .i_flush        (flush),
        .o_runs         (runs),
        .o_lane         (lane)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        w1;
        logic        w2;
        logic        lane;
        logic [15:0] runs;
    } ctl_t;

    ctl_t        ctl_q[$];
    logic [31:0] lane1_q[$];
    logic [31:0] lane2_q[$];
    logic [31:0] src_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: how many items the open run holds, which lane it targets,
    // whether the run has been closed and awaits its terminator, and runs completed.
    int          m_items   = 0;
    bit          m_lane    = 1'b0;
    bit          m_closing = 1'b0;
    logic [15:0] m_runs    = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic emit(input logic [31:0] value, ref ctl_t c);
        if (m_lane) begin
            lane2_q.push_back(value);
            c.w2 = 1'b1;
        end else begin
            lane1_q.push_back(value);
            c.w1 = 1'b1;
        end
    endtask

    // One clock of stimulus; the model decides the outcome from the inputs it drives.
    task automatic applyCycle(input bit rst, input bit fl, input bit r1, input bit r2, input bit gap);
        ctl_t c;
        bit   rdy;
        @(negedge clk);
        rst_n         = rst;
        flush         = fl;
        ready1        = r1;
        ready2        = r2;
        fifo_in_empty = gap || (src_q.size() == 0);
        fifo_in       = (src_q.size() != 0) ? src_q[0] : $urandom;
        if (!rst) begin
            m_items   = 0;
            m_lane    = 1'b0;
            m_closing = 1'b0;
            m_runs    = 16'd0;
        end
        c      = '0;
        c.runs = m_runs;
        c.lane = m_lane;
        rdy    = m_lane ? r2 : r1;
        if (rst) begin
            if (m_closing) begin
                if (rdy) begin
                    emit(TERMV, c);
                    m_lane    = ~m_lane;
                    m_runs    = m_runs + 16'd1;
                    m_items   = 0;
                    m_closing = 1'b0;
                end
            end else if (!fifo_in_empty && rdy) begin
                c.rd = 1'b1;
                emit(src_q.pop_front(), c);
                m_items++;
                if (m_items == RL || fl) m_closing = 1'b1;
            end else if (fl && m_items > 0) begin
                m_closing = 1'b1;
            end
        end
        ctl_q.push_back(c);
    endtask

    task automatic cyc(input bit fl, input bit r1, input bit r2);
        applyCycle(1'b1, fl, r1, r2, 1'b0);
    endtask

    task automatic pushRange(input int first, input int last);
        for (int v = first; v <= last; v++) src_q.push_back(32'(v));
    endtask

    // Monitor: sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        ctl_t        c;
        logic [31:0] exp_d;
        #2;
        if (ctl_q.size() != 0) begin
            c = ctl_q.pop_front();
            check("read_strobe", 32'(fifo_in_read), 32'(c.rd));
            check("write1_strobe", 32'(write1), 32'(c.w1));
            check("write2_strobe", 32'(write2), 32'(c.w2));
            check("runs_count", 32'(runs), 32'(c.runs));
            check("lane_select", 32'(lane), 32'(c.lane));
            if (write1 === 1'b1) begin
                if (lane1_q.size() == 0) check("lane1_unexpected_write", data, 32'hDEAD_BEEF);
                else begin
                    exp_d = lane1_q.pop_front();
                    check("lane1_data", data, exp_d);
                end
            end
            if (write2 === 1'b1) begin
                if (lane2_q.size() == 0) check("lane2_unexpected_write", data, 32'hDEAD_BEEF);
                else begin
                    exp_d = lane2_q.pop_front();
                    check("lane2_data", data, exp_d);
                end
            end
        end
    end

    initial begin
        // Reset state
        applyCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Two full runs, both lanes ready
        pushRange(1, 8);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);

        // Lane 1 stalled for cycles 2..4 while lane 2 stays ready
        pushRange(9, 16);
        for (int i = 0; i < 14; i++) cyc(1'b0, !(i >= 2 && i <= 4), 1'b1);

        // Flush a partial run from an empty source, then a flush with no items
        pushRange(1, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);

        // Flush on a run-completing item, then on a non-completing item
        pushRange(1, 4);
        for (int i = 0; i < 6; i++) cyc(i == 3, 1'b1, 1'b1);
        pushRange(1, 2);
        for (int i = 0; i < 4; i++) cyc(i == 1, 1'b1, 1'b1);

        // Terminator held off by backpressure, flush ignored while closing
        pushRange(20, 23);
        for (int i = 0; i < 8; i++) cyc(i == 5, i != 4 && i != 5, i != 4 && i != 5);

        // Reset mid-run abandons the partial run
        pushRange(1, 4);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        src_q.delete();
        applyCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pushRange(9, 12);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);

        // Run counter wrap: preset to 0xFFFF, then finish one more run
        #4;
        force dut.o_runs = 16'hFFFF;
        #1;
        release dut.o_runs;
        m_runs = 16'hFFFF;
        pushRange(30, 33);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0) src_q.push_back($urandom);
            if ($urandom_range(0, 499) == 0) begin
                src_q.delete();
                applyCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            end else begin
                applyCycle(1'b1, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            end
        end

        // Drain: let any closing run write its terminator
        src_q.delete();
        for (int i = 0; i < 4; i++) applyCycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #4;
        check("lane1_leftover", 32'(lane1_q.size()), 32'd0);
        check("lane2_leftover", 32'(lane2_q.size()), 32'd0);
        check("ctl_leftover", 32'(ctl_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_distributor.md
# run_distributor

Splits a single sorted-item source stream into runs of `RUN_LEN` items and deals them alternately into the two input FIFOs of `MERGER_1`. It appends a terminator word after every run. It is the transmit side of the merger input interface: it drives the FIFO write strobe and data that the merger later consumes through its empty/read handshake. It sits between the input-loading FIFO and the merger's lane 1 and lane 2 FIFOs.

## Interface
**Parameters**
- `DATA_W`, 32, item width.
- `RUN_LEN`, 4, data items per run (≥1).
- `TERM`, 0, terminator value written after each run.

**Ports**
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_fifo_in`  in  `DATA_W`  head item of the source FIFO (first-word-fall-through).
- `i_fifo_in_empty`  in  1  source FIFO empty.
- `o_fifo_in_read`  out  1  pop source head at this edge.
- `i_fifo_1_ready`  in  1  lane 1 FIFO accepts a write this edge (`~full | read`).
- `i_fifo_2_ready`  in  1  lane 2 FIFO accepts a write this edge.
- `o_fifo_1_write`  out  1  write `o_data` into lane 1.
- `o_fifo_2_write`  out  1  write `o_data` into lane 2.
- `o_data`  out  `DATA_W`  shared write data for both lanes.
- `i_flush`  in  1  single-cycle pulse: close the current partial run.
- `o_runs`  out  16  count of completed runs (terminator written); wraps.
- `o_lane`  out  1  current lane (0 = lane 1, 1 = lane 2).

## Operation
- **Registered state:**
  - `state` ∈ {`S_DATA`, `S_TERM`}.
  - `lane`.
  - `cnt` (`$clog2(RUN_LEN+1)` bits).
  - `flush_pend`.
  - `o_runs`.
- **Strobes** are combinational from the state and handshake inputs, and are forced to 0 while `i_rst_n` = 0.
- **`S_DATA`:**
  - Transfer when `~i_fifo_in_empty & ready[lane]`.
  - On a transfer: `o_fifo_in_read` = 1, `write[lane]` = 1, `o_data` = `i_fifo_in`, `cnt++`.
  - When the transfer makes `cnt == RUN_LEN`, or `flush_pend | i_flush` is set with `cnt+1 ≥ 1`, go to `S_TERM`.
  - `flush_pend` with `cnt == 0` and no transfer: clear `flush_pend` and stay (no empty runs).
- **`S_TERM`:**
  - `o_data` = `TERM`.
  - `write[lane]` = `ready[lane]`.
  - `o_fifo_in_read` = 0.
  - On the write: `cnt` ← 0, `lane` ← `~lane`, `o_runs++`, `flush_pend` ← 0, go to `S_DATA`.
- **`i_flush`** in `S_DATA` without a transfer and with `cnt > 0`: go to `S_TERM` next edge. With `cnt == 0`: ignored.
- **`i_flush`** in `S_TERM`: ignored (the run is already closing).
- **Items equal to `TERM`** are passed through unchanged. Excluding them is upstream's responsibility.
- **The idle lane** is never written. Backpressure on the active lane stalls the source even if the other lane is ready.

## Timing
- **Reset values:**
  - `state` = `S_DATA`, `lane` = 0, `cnt` = 0, `flush_pend` = 0.
  - `o_runs` = 0, `o_lane` = 0.
  - All strobes 0; `o_data` = `i_fifo_in`.
- **Latency:**
  - Data path is zero-cycle pass-through: the item is at the source head and in the lane FIFO on the same edge.
  - Terminator occupies exactly one accepted-write cycle.
- **Throughput:**
  - One item per cycle under no backpressure.
  - A full run costs `RUN_LEN+1` cycles.
- **Flush pulse timing:**
  - A flush pulse coincident with a run-completing transfer yields one terminator only.
  - A flush coincident with a non-completing transfer includes that item, then `TERM` on the next cycle.
- **Full/empty:**
  - Empty source: no strobes, state held.
  - `ready[lane]` = 0: all strobes 0, state held, including in `S_TERM`.
- **`o_runs`** wraps from 0xFFFF to 0.
- **Reset mid-run:** the partial run is abandoned with no terminator. Strobes drop in the same cycle `i_rst_n` falls.

## Structure
- Shared package `bonsai_pkg`:
  - `DATA_W` default.
  - `TERM` constant.
  - `dist_state_t` enum {`S_DATA`, `S_TERM`}.
- Single module, no sub-module: one FSM with counter, lane register and run counter.

## Test plan
- **Basic runs.** `RUN_LEN` = 4, source 1..8, both lanes ready.
  - Lane 1 gets 1,2,3,4,0; lane 2 gets 5,6,7,8,0.
  - `o_runs` = 2; total 10 cycles.
- **Backpressure.** `i_fifo_1_ready` low for cycles 2–4 while lane 2 is ready.
  - No reads or writes during the stall; lane 2 untouched.
  - Order on lane 1 is preserved.
- **Flush.** Source 1,2,3, then empty; pulse `i_flush`.
  - Lane 1 gets 1,2,3,0; `o_runs` = 1; `lane` = 1.
  - A second flush with `cnt` = 0 writes nothing.
- **Simultaneous flush.** `i_flush` on the cycle of the 4th item.
  - Exactly one 0 follows 4 on lane 1.
  - `i_flush` on the 2nd item gives 1,2,0.
- **Reset mid-run.** Assert `i_rst_n` = 0 after 2 items.
  - Strobes drop immediately.
  - After release, source 9..12 go to lane 1 followed by 0; `o_runs` restarts at 0.
- **Wrap.** Preload `o_runs` to 0xFFFF via 65535 runs (or force), then complete one more run → `o_runs` = 0.
